// File: rtl/axi_ddr_line_rd_master.sv
// ---------------------------------------------------------------------------
// axi_ddr_line_rd_master
//
// Purpose:
//   AXI4 read master that fetches one display line from the DDR frame buffer
//   for each accepted line request. The line is read as a chain of INCR
//   bursts with only one burst outstanding at a time. Every returned beat is
//   copied unmodified into the pixel FIFO that feeds the video read-out
//   stage. A line counter selects which frame line is fetched next. The
//   frame-sync pulse (the FIFO reset) rewinds that counter to line 0.
//
// Optional feature (compile-time macro RD_ERR_CNT_EN):
//   When defined, adds output rd_err_cnt[15:0]. The counter is a saturating
//   count of accepted beats whose RRESP is non-OKAY. Frame sync clears it.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN   clock, asynchronous active-low reset
//   AXI_FULL_BURST_VALID/READY  line request handshake from the read-out stage
//   frame_sync_n                active-low frame rewind
//   M_AXI_AR*                   AXI4 read address channel (ARID constant 0)
//   M_AXI_R*                    AXI4 read data channel
//   fifo_full                   pixel FIFO full (back-pressure)
//   fifo_wr_en, fifo_wr_data    registered pixel FIFO write port
//   rd_err_cnt                  error beat counter (RD_ERR_CNT_EN only)
// ---------------------------------------------------------------------------
module axi_ddr_line_rd_master #(
  parameter int                         AXI4_DATA_WIDTH = 128,
  parameter int                         AXI4_ADDR_WIDTH = 32,
  parameter int                         AXI4_ID_WIDTH   = 4,
  parameter logic [AXI4_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                         H_DISP          = 1280,
  parameter int                         V_DISP          = 720,
  parameter int                         BYTES_PER_PIXEL = 4,
  parameter int                         MAX_BURST_LEN   = 64
) (
  input  logic                       M_AXI_ACLK,
  input  logic                       M_AXI_ARESETN,
  input  logic                       AXI_FULL_BURST_VALID,
  output logic                       AXI_FULL_BURST_READY,
  input  logic                       frame_sync_n,
  output logic [AXI4_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [AXI4_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                 M_AXI_ARLEN,
  output logic [2:0]                 M_AXI_ARSIZE,
  output logic [1:0]                 M_AXI_ARBURST,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  input  logic [AXI4_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RLAST,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [AXI4_DATA_WIDTH-1:0] fifo_wr_data
`ifdef RD_ERR_CNT_EN
  ,
  output logic [15:0]                rd_err_cnt
`endif
);

  localparam int LINE_BYTES  = H_DISP * BYTES_PER_PIXEL;
  localparam int LINE_BEATS  = LINE_BYTES * 8 / AXI4_DATA_WIDTH;
  localparam int BURST_BYTES = MAX_BURST_LEN * AXI4_DATA_WIDTH / 8;
  localparam int BEAT_W      = $clog2(LINE_BEATS + 1);
  localparam int LINE_W      = (V_DISP > 1) ? $clog2(V_DISP) : 1;
  localparam int SIZE_CODE   = $clog2(AXI4_DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                       state_reg;
  state_t                       state_next;
  logic [AXI4_ADDR_WIDTH-1:0]   line_addr_reg;
  logic [BEAT_W-1:0]            beats_left_reg;
  logic [7:0]                   arlen_reg;
  logic [LINE_W-1:0]            line_idx_reg;
  logic                         abort_reg;
  logic                         wr_en_reg;
  logic [AXI4_DATA_WIDTH-1:0]   wr_data_reg;

  logic                         req_ready;
  logic                         ar_valid;
  logic                         r_ready;
  logic                         drain;
  logic                         accept;
  logic                         ar_hs;
  logic                         beat;
  logic                         last_beat;
  logic                         line_end;
  logic [AXI4_ADDR_WIDTH-1:0]   line_base;
  logic [BEAT_W-1:0]            burst_beats;

  // ARLEN for the next burst given the beats still to be requested.
  // The comparison is done in 32 bits so a burst length larger than the
  // whole line cannot be truncated by the narrow beat counter.
  function automatic logic [7:0] burst_arlen(input logic [BEAT_W-1:0] beats);
    if (int'(beats) >= MAX_BURST_LEN) begin
      return 8'(MAX_BURST_LEN - 1);
    end else begin
      return 8'(int'(beats) - 1);
    end
  endfunction

  // While a rewind is pending (or being signalled right now) the burst in
  // flight is drained: RREADY is forced high and nothing reaches the FIFO.
  assign drain       = abort_reg | ~frame_sync_n;
  assign accept      = req_ready & AXI_FULL_BURST_VALID;
  assign ar_hs       = ar_valid & M_AXI_ARREADY;
  assign beat        = r_ready & M_AXI_RVALID;
  assign last_beat   = beat & M_AXI_RLAST;
  assign line_end    = last_beat & (beats_left_reg == '0) & ~drain;
  assign line_base   = BASE_ADDR + AXI4_ADDR_WIDTH'(int'(line_idx_reg) * LINE_BYTES);
  assign burst_beats = BEAT_W'(arlen_reg) + BEAT_W'(1);

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Reset is folded in so READY reads 0 while reset is held.
        req_ready = frame_sync_n & M_AXI_ARESETN;
        if (AXI_FULL_BURST_VALID && req_ready) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        ar_valid = 1'b1;
        if (M_AXI_ARREADY) begin
          state_next = DATA;
        end
      end
      DATA: begin
        r_ready = drain | ~fifo_full;
        if (M_AXI_RVALID && r_ready && M_AXI_RLAST) begin
          // An aborted line drops its remaining bursts.
          if (beats_left_reg == '0 || drain) begin
            state_next = IDLE;
          end else begin
            state_next = ADDR;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_reg      <= IDLE;
      line_addr_reg  <= '0;
      beats_left_reg <= '0;
      arlen_reg      <= '0;
      line_idx_reg   <= '0;
      abort_reg      <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= '0;
    end else begin
      state_reg <= state_next;

      // Address/length bookkeeping. beats_left counts beats not yet
      // requested on AR, so it reaches 0 once the final burst is issued.
      if (accept) begin
        line_addr_reg  <= line_base;
        beats_left_reg <= BEAT_W'(LINE_BEATS);
        arlen_reg      <= burst_arlen(BEAT_W'(LINE_BEATS));
      end else if (ar_hs) begin
        beats_left_reg <= beats_left_reg - burst_beats;
        line_addr_reg  <= line_addr_reg + AXI4_ADDR_WIDTH'(BURST_BYTES);
      end else if (last_beat && state_next == ADDR) begin
        arlen_reg <= burst_arlen(beats_left_reg);
      end

      // Rewind has priority over advancing at end of line.
      if (!frame_sync_n) begin
        line_idx_reg <= '0;
      end else if (line_end) begin
        if (line_idx_reg == LINE_W'(V_DISP - 1)) begin
          line_idx_reg <= '0;
        end else begin
          line_idx_reg <= line_idx_reg + 1'b1;
        end
      end

      // Remember a rewind seen mid-line until the burst in flight ends.
      if (last_beat && state_next == IDLE) begin
        abort_reg <= 1'b0;
      end else if (!frame_sync_n && state_reg != IDLE) begin
        abort_reg <= 1'b1;
      end

      wr_en_reg <= beat & ~drain;
      if (beat) begin
        wr_data_reg <= M_AXI_RDATA;
      end
    end
  end

`ifdef RD_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      err_cnt_reg <= '0;
    end else if (!frame_sync_n) begin
      err_cnt_reg <= '0;
    end else if (beat && M_AXI_RRESP != 2'b00 && err_cnt_reg != 16'hFFFF) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign rd_err_cnt = err_cnt_reg;
`else
  // RRESP does not influence the data path when error counting is off.
  logic unused_rresp;
  assign unused_rresp = ^M_AXI_RRESP;
`endif

  assign AXI_FULL_BURST_READY = req_ready;
  assign M_AXI_ARID           = '0;
  assign M_AXI_ARADDR         = line_addr_reg;
  assign M_AXI_ARLEN          = arlen_reg;
  assign M_AXI_ARSIZE         = 3'(SIZE_CODE);
  assign M_AXI_ARBURST        = 2'b01;
  assign M_AXI_ARVALID        = ar_valid;
  assign M_AXI_RREADY         = r_ready;
  assign fifo_wr_en           = wr_en_reg;
  assign fifo_wr_data         = wr_data_reg;

endmodule

// File: tb/tb_axi_ddr_line_rd_master.sv
// ---------------------------------------------------------------------------
// tb_axi_ddr_line_rd_master
//
// Self-checking bench for axi_ddr_line_rd_master. The DUT is built with a
// reduced frame: 1152 pixels per line gives 288 beats, which is four full
// 64-beat bursts plus one 32-beat burst. The frame has 6 lines. Expected
// AR requests and FIFO words are queued before each request is issued. They
// are popped and compared as the DUT produces them. The slave returns
// RDATA = four copies of the byte address of each beat.
// ---------------------------------------------------------------------------
module tb_axi_ddr_line_rd_master;

  localparam int          DW          = 128;
  localparam int          AW          = 32;
  localparam int          IW          = 4;
  localparam int          HD          = 1152;
  localparam int          VD          = 6;
  localparam int          BPP         = 4;
  localparam int          MAXB        = 64;
  localparam logic [31:0] BASE        = 32'h0010_0000;
  localparam int          LINE_BEATS  = 288;
  localparam int          LINE_BYTES  = 4608;
  localparam int          BURST_BYTES = 1024;

  logic          clk;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic          fsync_n;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic          fifo_full;
  logic          wr_en;
  logic [DW-1:0] wr_data;
`ifdef RD_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  axi_ddr_line_rd_master #(
    .AXI4_DATA_WIDTH (DW),
    .AXI4_ADDR_WIDTH (AW),
    .AXI4_ID_WIDTH   (IW),
    .BASE_ADDR       (BASE),
    .H_DISP          (HD),
    .V_DISP          (VD),
    .BYTES_PER_PIXEL (BPP),
    .MAX_BURST_LEN   (MAXB)
  ) dut (
    .M_AXI_ACLK           (clk),
    .M_AXI_ARESETN        (rstn),
    .AXI_FULL_BURST_VALID (req_valid),
    .AXI_FULL_BURST_READY (req_ready),
    .frame_sync_n         (fsync_n),
    .M_AXI_ARID           (arid),
    .M_AXI_ARADDR         (araddr),
    .M_AXI_ARLEN          (arlen),
    .M_AXI_ARSIZE         (arsize),
    .M_AXI_ARBURST        (arburst),
    .M_AXI_ARVALID        (arvalid),
    .M_AXI_ARREADY        (arready),
    .M_AXI_RDATA          (rdata),
    .M_AXI_RRESP          (rresp),
    .M_AXI_RLAST          (rlast),
    .M_AXI_RVALID         (rvalid),
    .M_AXI_RREADY         (rready),
    .fifo_full            (fifo_full),
    .fifo_wr_en           (wr_en),
    .fifo_wr_data         (wr_data)
`ifdef RD_ERR_CNT_EN
    ,
    .rd_err_cnt           (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  logic [39:0]   exp_ar_q[$];   // {araddr, arlen}
  logic [DW-1:0] exp_wr_q[$];

  // Slave model state.
  bit          slv_active = 0;
  bit          r_pending  = 0;
  logic [31:0] slv_addr   = '0;
  logic [7:0]  slv_len    = '0;
  int          slv_beat   = 0;
  int          line_beats = 0;
  int          ar_cnt     = 0;
  int          wr_cnt     = 0;
  int          req_hs     = 0;
  bit          slow       = 0;
  bit          err_mode   = 0;

  typedef struct {
    bit          slow;
    int          stall_at;
    logic [31:0] addr;
    int          exp_ars;
    int          exp_beats;
  } vec_t;

  vec_t vec[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [31:0] a, input int nbursts, input int nbeats);
    int          rem;
    logic [31:0] ba;
    for (int k = 0; k < nbursts; k++) begin
      rem = LINE_BEATS - k * MAXB;
      exp_ar_q.push_back({a + 32'(k * BURST_BYTES), 8'(((rem > MAXB) ? MAXB : rem) - 1)});
    end
    for (int b = 0; b < nbeats; b++) begin
      ba = a + 32'(b * (DW / 8));
      exp_wr_q.push_back({4{ba}});
    end
  endtask

  // Slave and monitor. Inputs are driven on the falling edge; the transfers
  // that the next rising edge will perform are evaluated 1 time unit later.
  initial begin
    logic [31:0] beat_addr;
    logic [39:0] e_ar;
    logic [DW-1:0] e_wr;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    forever begin
      @(negedge clk);
      arready   = !slv_active && (!slow || ($urandom_range(0, 2) == 0));
      rvalid    = slv_active && (r_pending || !slow || ($urandom_range(0, 3) != 0));
      beat_addr = slv_addr + 32'(slv_beat * (DW / 8));
      rdata     = {4{beat_addr}};
      rlast     = slv_active && (slv_beat == int'(slv_len));
      rresp     = (err_mode && (line_beats == 10 || line_beats == 50 || line_beats == 200))
                  ? 2'b10 : 2'b00;
      #1;
      if (req_valid && req_ready) req_hs++;
      if (arvalid && arready) begin
        ar_cnt++;
        check("ar_attr", {arid, arsize, arburst}, {4'd0, 3'd4, 2'b01});
        if (exp_ar_q.size() == 0) begin
          check("ar_extra", {araddr, arlen}, 40'h0);
        end else begin
          e_ar = exp_ar_q.pop_front();
          check("ar_addr", araddr, e_ar[39:8]);
          check("ar_len", arlen, e_ar[7:0]);
        end
        slv_active = 1;
        slv_addr   = araddr;
        slv_len    = arlen;
        slv_beat   = 0;
      end
      r_pending = 0;
      if (rvalid) begin
        if (rready) begin
          line_beats++;
          if (rlast) slv_active = 0;
          else slv_beat++;
        end else begin
          r_pending = 1;
        end
      end
      if (wr_en) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) begin
          check("wr_extra", wr_data, '0);
        end else begin
          e_wr = exp_wr_q.pop_front();
          check("wr_data", wr_data, e_wr);
        end
      end
    end
  end

  task automatic send_req();
    int h0;
    bit ok;
    h0 = req_hs;
    ok = 0;
    @(negedge clk);
    req_valid = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      #2;
      if (req_hs != h0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("req_accept", ok, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int stall_at, output bit done);
    bit stalled;
    stalled = 0;
    done    = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (stall_at >= 0 && !stalled && line_beats == stall_at) begin
        stalled = 1;
        for (int c = 0; c < 10; c++) begin
          if (c > 0) @(negedge clk);
          fifo_full = 1'b1;
          #2;
          check("stall_rready", rready, 0);
          if (c > 0) check("stall_no_wr", wr_en, 0);
        end
        @(negedge clk);
        fifo_full = 1'b0;
      end
      #2;
      if (exp_ar_q.size() == 0 && exp_wr_q.size() == 0 && !slv_active && req_ready) begin
        done = 1;
        break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $fatal(1);
  end

  initial begin
    bit done;
    bit ok;
    bit busy_seen;
    int a0;
    int w0;
    int h0;
    int bad_rr;
    int bad_wr;

    // Lines 0..5 then wrap to 0,1; mixes zero-wait and random-wait slave.
    vec[0] = '{0, -1,  BASE + 32'(0 * LINE_BYTES), 5, LINE_BEATS};
    vec[1] = '{1, -1,  BASE + 32'(1 * LINE_BYTES), 5, LINE_BEATS};
    vec[2] = '{0, 30,  BASE + 32'(2 * LINE_BYTES), 5, LINE_BEATS};
    vec[3] = '{1, -1,  BASE + 32'(3 * LINE_BYTES), 5, LINE_BEATS};
    vec[4] = '{0, -1,  BASE + 32'(4 * LINE_BYTES), 5, LINE_BEATS};
    vec[5] = '{1, 100, BASE + 32'(5 * LINE_BYTES), 5, LINE_BEATS};
    vec[6] = '{0, -1,  BASE,                       5, LINE_BEATS};
    vec[7] = '{0, -1,  BASE + 32'(LINE_BYTES),     5, LINE_BEATS};

    rstn      = 1'b0;
    req_valid = 1'b0;
    fsync_n   = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_ready", req_ready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
`ifdef RD_ERR_CNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #2;
    check("idle_ready", req_ready, 1);

    // Table-driven single-line requests.
    for (int i = 0; i < 8; i++) begin
      a0   = ar_cnt;
      w0   = wr_cnt;
      slow = vec[i].slow;
      push_line(vec[i].addr, 5, LINE_BEATS);
      line_beats = 0;
      send_req();
      wait_done(vec[i].stall_at, done);
      check("line_done", done, 1);
      check("ar_count", ar_cnt - a0, vec[i].exp_ars);
      check("wr_count", wr_cnt - w0, vec[i].exp_beats);
      check("ready_after", req_ready, 1);
    end
    slow = 0;

    // VALID held while busy: second line only accepted after the first.
    a0 = ar_cnt;
    push_line(BASE + 32'(2 * LINE_BYTES), 5, LINE_BEATS);
    push_line(BASE + 32'(3 * LINE_BYTES), 5, LINE_BEATS);
    h0 = req_hs;
    line_beats = 0;
    @(negedge clk);
    req_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      #2;
      if (req_hs != h0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("busy_first_accept", ok, 1);
    busy_seen = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      #2;
      if (req_ready) busy_seen = 1;
    end
    check("busy_ready", busy_seen, 0);
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #2;
      if (req_hs == h0 + 2) begin
        ok = 1;
        break;
      end
    end
    check("busy_second_accept", ok, 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done(-1, done);
    check("busy_done", done, 1);
    check("busy_ar_count", ar_cnt - a0, 10);

    // Frame sync during beat 100 of line 4: burst 1 drained, rest dropped.
    a0 = ar_cnt;
    w0 = wr_cnt;
    push_line(BASE + 32'(4 * LINE_BYTES), 2, 100);
    line_beats = 0;
    send_req();
    ok = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (line_beats == 100) begin
        ok = 1;
        break;
      end
    end
    check("abort_reach_beat", ok, 1);
    fsync_n = 1'b0;
    @(negedge clk);
    fsync_n   = 1'b1;
    fifo_full = 1'b1;
    bad_rr = 0;
    bad_wr = 0;
    done   = 0;
    for (int n = 0; n < 500; n++) begin
      #2;
      if (req_ready) begin
        done = 1;
        break;
      end
      if (slv_active && !rready) bad_rr++;
      if (wr_en) bad_wr++;
      @(negedge clk);
    end
    fifo_full = 1'b0;
    check("abort_idle", done, 1);
    check("drain_rready", bad_rr, 0);
    check("drain_no_wr", bad_wr, 0);
    repeat (30) @(negedge clk);
    #2;
    check("abort_ar_count", ar_cnt - a0, 2);
    check("abort_wr_count", wr_cnt - w0, 100);
    check("abort_q_empty", exp_ar_q.size() + exp_wr_q.size(), 0);

    // VALID and frame sync together in IDLE: rewind wins, then line 0.
    a0 = ar_cnt;
    push_line(BASE, 5, LINE_BEATS);
    line_beats = 0;
    h0 = req_hs;
    @(negedge clk);
    req_valid = 1'b1;
    fsync_n   = 1'b0;
    #2;
    check("rewind_ready", req_ready, 0);
    @(negedge clk);
    fsync_n = 1'b1;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      #2;
      if (req_hs != h0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("rewind_accept", ok, 1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done(-1, done);
    check("rewind_done", done, 1);
    check("rewind_ar_count", ar_cnt - a0, 5);

`ifdef RD_ERR_CNT_EN
    // Three SLVERR beats in line 1, then clear by frame sync.
    err_mode = 1;
    push_line(BASE + 32'(LINE_BYTES), 5, LINE_BEATS);
    line_beats = 0;
    send_req();
    wait_done(-1, done);
    err_mode = 0;
    check("err_done", done, 1);
    check("err_cnt", err_cnt, 3);
    @(negedge clk);
    fsync_n = 1'b0;
    @(negedge clk);
    fsync_n = 1'b1;
    #2;
    check("err_clear", err_cnt, 0);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
